// File: rtl/noc_page_server_if.sv
// Request/reply/query/response bundle between the ant array and the page server.
// The master side is the ant array and the slave side is the server.
interface noc_page_server_if #(
    parameter int NUM_ANT = 4,
    parameter int WIDTH   = 32,
    parameter int PID_W   = 6
);
    logic [NUM_ANT*(PID_W+1)-1:0]       req;    // per ant: {page_id, valid}
    logic [NUM_ANT*WIDTH-1:0]           reply;  // per ant: value for the page on its query lane
    logic [NUM_ANT*PID_W-1:0]           query;  // per ant: page_id presented to that owner
    logic [NUM_ANT*(WIDTH+PID_W+1)-1:0] resp;   // per ant: {data, page_id, valid}

    modport master (output req, output reply, input query, input resp);
    modport slave  (input req, input reply, output query, output resp);
endinterface

// File: rtl/noc_page_server.sv
// Page server for the PageRank ant array. It takes one {page_id,valid} request per ant,
// queries the owning ant, and returns the sampled value to the requester in round-robin order.
module noc_page_server #(
    parameter int NUM_ANT = 4,
    parameter int N       = 16,
    parameter int WIDTH   = 32,
    parameter int PID_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    noc_page_server_if.slave    bus,
    output logic                busy_o,
    output logic [15:0]         txn_count_o,
    output logic [7:0]          err_count_o
);
    localparam int REQ_W = PID_W + 1;
    localparam int RSP_W = WIDTH + PID_W + 1;
    localparam int IDX_W = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e               state_q;
    logic                 busy_q;

    logic [NUM_ANT-1:0]   req_valid;
    logic [PID_W-1:0]     req_pid   [NUM_ANT];
    logic [WIDTH-1:0]     reply_arr [NUM_ANT];

    logic [NUM_ANT-1:0]   pending_q;
    logic [NUM_ANT-1:0]   armed_q;
    logic [PID_W-1:0]     pid_q     [NUM_ANT];

    logic [IDX_W-1:0]     rr_q;
    logic [IDX_W-1:0]     gnt_q;
    logic [IDX_W-1:0]     gnt_d;
    logic                 gnt_found;
    logic [IDX_W-1:0]     cand;
    logic [PID_W-1:0]     owner_d;
    logic                 owner_ok;
    logic [IDX_W-1:0]     own_q;
    logic                 err_q;
    logic [WIDTH-1:0]     data_q;

    logic [PID_W-1:0]     query_q    [NUM_ANT];
    logic [WIDTH-1:0]     rsp_data_q [NUM_ANT];
    logic [PID_W-1:0]     rsp_pid_q  [NUM_ANT];
    logic [NUM_ANT-1:0]   rsp_valid_q;

    logic [15:0]          txn_q;
    logic [7:0]           err_cnt_q;

    // Flat interface vectors <-> per-port views.
    for (genvar k = 0; k < NUM_ANT; k++) begin : g_port
        assign req_valid[k] = bus.req[k*REQ_W];
        assign req_pid[k]   = bus.req[k*REQ_W+1 +: PID_W];
        assign reply_arr[k] = bus.reply[k*WIDTH +: WIDTH];
        assign bus.query[k*PID_W +: PID_W] = query_q[k];
        assign bus.resp[k*RSP_W +: RSP_W]  = {rsp_data_q[k], rsp_pid_q[k], rsp_valid_q[k]};
    end

    // Round-robin search: first pending port strictly after the last grant, wrapping.
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_d     = rr_q;
        cand      = '0;
        for (int i = 1; i <= NUM_ANT; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % NUM_ANT);
            if (!gnt_found && pending_q[cand]) begin
                gnt_found = 1'b1;
                gnt_d     = cand;
            end
        end
    end

    assign owner_d  = pid_q[gnt_d] / PID_W'(N);
    assign owner_ok = owner_d < PID_W'(NUM_ANT);

    // NOTE: sequential state is written only with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rr_q        <= IDX_W'(NUM_ANT - 1);
            gnt_q       <= '0;
            own_q       <= '0;
            err_q       <= 1'b0;
            data_q      <= '0;
            pending_q   <= '0;
            armed_q     <= '1;
            rsp_valid_q <= '0;
            txn_q       <= '0;
            err_cnt_q   <= '0;
            // NOTE: these arrays are a handful of flops with defined reset values, not a RAM,
            // so resetting them in full is intended and cheap.
            for (int k = 0; k < NUM_ANT; k++) begin
                pid_q[k]      <= '0;
                query_q[k]    <= '0;
                rsp_data_q[k] <= '0;
                rsp_pid_q[k]  <= '0;
            end
        end else begin
            rsp_valid_q <= '0;

            // Capture: a held valid is served once. Dropping valid, or changing page_id while
            // idle (the ant's timeout retry), re-arms the port.
            for (int k = 0; k < NUM_ANT; k++) begin
                if (!req_valid[k] || (!pending_q[k] && (req_pid[k] != pid_q[k]))) begin
                    armed_q[k] <= 1'b1;
                end
                if (armed_q[k] && req_valid[k] && !pending_q[k]) begin
                    pending_q[k] <= 1'b1;
                    armed_q[k]   <= 1'b0;
                    pid_q[k]     <= req_pid[k];
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        rr_q    <= gnt_d;
                        gnt_q   <= gnt_d;
                        own_q   <= IDX_W'(owner_d);
                        err_q   <= !owner_ok;
                        if (owner_ok) begin
                            query_q[IDX_W'(owner_d)] <= pid_q[gnt_d];
                        end
                        state_q <= QUERY;
                        busy_q  <= 1'b1;
                    end
                end
                QUERY: begin
                    data_q  <= err_q ? '0 : reply_arr[own_q];
                    state_q <= RESP;
                end
                RESP: begin
                    rsp_data_q[gnt_q]  <= data_q;
                    rsp_pid_q[gnt_q]   <= pid_q[gnt_q];
                    rsp_valid_q[gnt_q] <= 1'b1;
                    pending_q[gnt_q]   <= 1'b0;
                    txn_q              <= txn_q + 16'd1;
                    if (err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign txn_count_o = txn_q;
    assign err_count_o = err_cnt_q;
endmodule

// File: tb/tb_noc_page_server.sv
// Directed bench for noc_page_server: a scoreboard of expected responses is filled as requests
// are driven and drained by a response monitor; dut_b (N=8) covers out-of-range owners.
module tb_noc_page_server;
    localparam int NUM_ANT = 4;
    localparam int WIDTH   = 32;
    localparam int PID_W   = 6;
    localparam int REQ_W   = PID_W + 1;
    localparam int RSP_W   = WIDTH + PID_W + 1;

    typedef struct {
        int               port;
        logic [WIDTH-1:0] data;
        logic [PID_W-1:0] pid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy_a, busy_b;
    logic [15:0] txn_a, txn_b;
    logic [7:0]  errc_a, errc_b;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   resp_cyc_q[$];
    exp_t mon_e;
    logic [NUM_ANT-1:0] prev_valid = '0;

    noc_page_server_if #(.NUM_ANT(NUM_ANT), .WIDTH(WIDTH), .PID_W(PID_W)) bus_a ();
    noc_page_server_if #(.NUM_ANT(NUM_ANT), .WIDTH(WIDTH), .PID_W(PID_W)) bus_b ();

    noc_page_server #(.NUM_ANT(NUM_ANT), .N(16), .WIDTH(WIDTH), .PID_W(PID_W)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .busy_o(busy_a), .txn_count_o(txn_a), .err_count_o(errc_a)
    );
    noc_page_server #(.NUM_ANT(NUM_ANT), .N(8), .WIDTH(WIDTH), .PID_W(PID_W)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .busy_o(busy_b), .txn_count_o(txn_b), .err_count_o(errc_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Ant model: combinational reply for whatever page the server presents.
    function automatic logic [WIDTH-1:0] reply_fn(input int ant, input logic [PID_W-1:0] pid);
        if (pid == 6'h25) return 32'h1234_5678;
        return {16'hC0DE, 8'(ant), 2'b00, pid};
    endfunction

    for (genvar k = 0; k < NUM_ANT; k++) begin : g_ant
        assign bus_a.reply[k*WIDTH +: WIDTH] = reply_fn(k, bus_a.query[k*PID_W +: PID_W]);
        assign bus_b.reply[k*WIDTH +: WIDTH] = reply_fn(k, bus_b.query[k*PID_W +: PID_W]);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input int port, input logic [PID_W-1:0] pid, input logic v);
        bus_a.req[port*REQ_W +: REQ_W] = {pid, v};
    endtask

    task automatic expect_a(input int port, input logic [PID_W-1:0] pid);
        exp_t e;
        e.port = port;
        e.pid  = pid;
        e.data = reply_fn(int'(pid) / 16, pid);
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 200 && sb_q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check(tag, 64'(sb_q.size()), 64'd0);
    endtask

    // Response monitor for dut_a: every valid pulse must match the scoreboard head and last one cycle.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_ANT; k++) begin
                if (bus_a.resp[k*RSP_W]) begin
                    check("resp_pulse_width", 64'(prev_valid[k]), 64'd0);
                    check("resp_expected", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        mon_e = sb_q.pop_front();
                        check("resp_port", 64'(k), 64'(mon_e.port));
                        check("resp_data", 64'(bus_a.resp[k*RSP_W+PID_W+1 +: WIDTH]), 64'(mon_e.data));
                        check("resp_pid", 64'(bus_a.resp[k*RSP_W+1 +: PID_W]), 64'(mon_e.pid));
                        resp_cyc_q.push_back(cyc);
                    end
                end
                prev_valid[k] = bus_a.resp[k*RSP_W];
            end
        end else begin
            prev_valid = '0;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        logic [RSP_W-1:0] rb;

        bus_a.req = '0;
        bus_b.req = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_txn", 64'(txn_a), 64'd0);
        check("rst_err", 64'(errc_a), 64'd0);
        check("rst_query", 64'(bus_a.query), 64'd0);
        check("rst_resp_lo", bus_a.resp[63:0], 64'd0);
        check("rst_resp_hi", 64'(bus_a.resp[NUM_ANT*RSP_W-1:64]), 64'd0);
        reset = 1'b0;

        // 1: ant1 asks for page 0x25, owned by ant2
        @(negedge clk);
        expect_a(1, 6'h25);
        drive_a(1, 6'h25, 1'b1);
        @(posedge clk);  // E0
        @(posedge clk);  // E1
        @(negedge clk);
        check("t1_query2", 64'(bus_a.query[2*PID_W +: PID_W]), 64'h25);
        check("t1_busy", 64'(busy_a), 64'd1);
        @(posedge clk);  // E2
        @(posedge clk);  // E3
        @(negedge clk);
        rb = bus_a.resp[1*RSP_W +: RSP_W];
        check("t1_resp_e3", 64'(rb), {25'd0, 32'h1234_5678, 6'h25, 1'b1});
        @(negedge clk);
        check("t1_valid_e4", 64'(bus_a.resp[1*RSP_W]), 64'd0);
        check("t1_data_hold", 64'(bus_a.resp[1*RSP_W+PID_W+1 +: WIDTH]), 64'h1234_5678);
        check("t1_txn", 64'(txn_a), 64'd1);
        drain("t1_drain");

        // 2: all four ports request on one edge after reset
        reset = 1'b1;
        bus_a.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        resp_cyc_q.delete();
        expect_a(0, 6'h01);
        expect_a(1, 6'h13);
        expect_a(2, 6'h2A);
        expect_a(3, 6'h3C);
        drive_a(0, 6'h01, 1'b1);
        drive_a(1, 6'h13, 1'b1);
        drive_a(2, 6'h2A, 1'b1);
        drive_a(3, 6'h3C, 1'b1);
        drain("t2_drain");
        check("t2_count", 64'(resp_cyc_q.size()), 64'd4);
        if (resp_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("t2_gap", 64'(resp_cyc_q[i] - resp_cyc_q[i-1]), 64'd3);
            end
        end
        // Fifth round: only ports 2 and 3 re-request
        bus_a.req = '0;
        @(negedge clk);
        expect_a(2, 6'h2A);
        expect_a(3, 6'h3C);
        drive_a(2, 6'h2A, 1'b1);
        drive_a(3, 6'h3C, 1'b1);
        drain("t2_round5_drain");
        check("t2_txn", 64'(txn_a), 64'd6);

        // 3: held valid is served once; drop-and-reassert or page change is served again
        expect_a(0, 6'h05);
        drive_a(0, 6'h05, 1'b1);
        drain("t3_first_drain");
        repeat (10) @(negedge clk);
        check("t3_no_reserve", 64'(txn_a), 64'd7);
        drive_a(0, 6'h05, 1'b0);
        @(negedge clk);
        expect_a(0, 6'h05);
        drive_a(0, 6'h05, 1'b1);
        drain("t3_reassert_drain");
        expect_a(0, 6'h31);
        drive_a(0, 6'h31, 1'b1);
        drain("t3_newpid_drain");
        check("t3_txn", 64'(txn_a), 64'd9);

        // 5: N=8 build, page 0x3F belongs to nonexistent owner 7
        @(negedge clk);
        bus_b.req[1*REQ_W +: REQ_W] = {6'h3F, 1'b1};
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = bus_b.resp[1*RSP_W];
        end
        check("t5_resp_seen", 64'(found), 64'd1);
        check("t5_data", 64'(bus_b.resp[1*RSP_W+PID_W+1 +: WIDTH]), 64'd0);
        check("t5_pid", 64'(bus_b.resp[1*RSP_W+1 +: PID_W]), 64'h3F);
        check("t5_errc", 64'(errc_b), 64'd1);
        check("t5_txn", 64'(txn_b), 64'd1);
        check("t5_no_query", 64'(bus_b.query), 64'd0);
        bus_b.req = '0;

        // 4: reset in the middle of a transaction
        bus_a.req = '0;
        repeat (3) @(negedge clk);
        drive_a(3, 6'h07, 1'b1);
        @(posedge clk);  // E0
        @(posedge clk);  // E1 -> QUERY
        @(negedge clk);
        check("t4_busy_before", 64'(busy_a), 64'd1);
        reset = 1'b1;
        #1;
        check("t4_busy_reset", 64'(busy_a), 64'd0);
        check("t4_txn_reset", 64'(txn_a), 64'd0);
        check("t4_errb_reset", 64'(errc_b), 64'd0);
        check("t4_query_reset", 64'(bus_a.query), 64'd0);
        bus_a.req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_no_resp", 64'(txn_a), 64'd0);
        expect_a(2, 6'h15);
        drive_a(2, 6'h15, 1'b1);
        drain("t4_after_drain");
        check("t4_txn_after", 64'(txn_a), 64'd1);

        // 6: transaction counter wraps 0xFFFF -> 0
        @(negedge clk);
        force dut_a.txn_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.txn_q;
        @(negedge clk);
        check("t6_preload", 64'(txn_a), 64'hFFFF);
        expect_a(1, 6'h2E);
        drive_a(1, 6'h2E, 1'b1);
        drain("t6_drain");
        check("t6_wrap", 64'(txn_a), 64'd0);
        check("t6_errc", 64'(errc_a), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
